vga_compositor: RTL and testbench

- Drives the 640x480@60 VGA output for the game.
- Generates `hcount`/`vcount` for all sprite renderers and receives their registered colour/data outputs one pixel tick later.
- Merges the sprite layers by fixed priority over a background colour and re-aligns the sync signals to the pixel pipeline.
- Reports per-frame player-vs-layer collisions to the game logic.

---
 rtl/vga_compositor_if.sv | 34 +++
 rtl/vga_compositor.sv | 127 ++++++++++++
 tb/tb_vga_compositor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_compositor_if.sv
// Pixel-side bus between the VGA compositor and the game/sprite logic.
// The compositor is the slave; renderers and game logic are the master side.
interface vga_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic                      enable;
    logic [9:0]                hcount;
    logic [9:0]                vcount;
    logic [NUM_LAYERS-1:0]     layer_data;
    logic [8*NUM_LAYERS-1:0]   layer_rgb;
    logic [7:0]                bg_rgb;
    logic                      hsync;
    logic                      vsync;
    logic [2:0]                red;
    logic [2:0]                green;
    logic [1:0]                blue;
    logic                      frame_start;
    logic [NUM_LAYERS-2:0]     collision;
    logic                      collision_valid;

    modport master (
        output enable, layer_data, layer_rgb, bg_rgb,
        input  hcount, vcount, hsync, vsync,
        input  red, green, blue,
        input  frame_start, collision, collision_valid
    );

    modport slave (
        input  enable, layer_data, layer_rgb, bg_rgb,
        output hcount, vcount, hsync, vsync,
        output red, green, blue,
        output frame_start, collision, collision_valid
    );
endinterface

// File: rtl/vga_compositor.sv
// VGA timing, fixed-priority sprite mixer and per-frame player collision report.
// Sync and colour share one two-tick pipeline so they reach the pins together.
module vga_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input logic              clock,
    input logic              reset,
    vga_compositor_if.slave  bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]            hcnt;
    logic [9:0]            vcnt;
    logic                  h_end;
    logic                  frame_end;
    logic                  act0;
    logic                  hs0;
    logic                  vs0;
    logic                  act1;
    logic                  hs1;
    logic                  vs1;
    logic                  hs2;
    logic                  vs2;
    logic [7:0]            pix;
    logic [7:0]            pix_q;
    logic [NUM_LAYERS-2:0] hit;
    logic [NUM_LAYERS-2:0] acc;
    logic [NUM_LAYERS-2:0] coll;
    logic                  fs_q;

    assign h_end     = (hcnt == H_LAST);
    assign frame_end = h_end && (vcnt == V_LAST);

    // Sync flags are carried active-high so cleared pipeline regs mean "no sync".
    assign act0 = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hs0  = (hcnt >= H_SS) && (hcnt < H_SE);
    assign vs0  = (vcnt >= V_SS) && (vcnt < V_SE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (bus.enable) begin
            if (h_end) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Walk from the highest layer down so the lowest opaque index wins.
    always_comb begin
        pix = bus.bg_rgb;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (bus.layer_data[k]) pix = bus.layer_rgb[8*k +: 8];
        end
        if (!act1) pix = '0;
    end

    always_comb begin
        hit = '0;
        for (int k = 1; k < NUM_LAYERS; k++) begin
            hit[k-1] = bus.layer_data[0] & bus.layer_data[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act1  <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            hs2   <= 1'b0;
            vs2   <= 1'b0;
            pix_q <= '0;
            acc   <= '0;
            coll  <= '0;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= bus.enable && frame_end;
            if (bus.enable) begin
                act1  <= act0;
                hs1   <= hs0;
                vs1   <= vs0;
                hs2   <= hs1;
                vs2   <= vs1;
                pix_q <= pix;
                if (frame_end) begin
                    coll <= acc;
                    acc  <= '0;
                end else if (act1) begin
                    acc <= acc | hit;
                end
            end
        end
    end

    assign bus.hcount          = hcnt;
    assign bus.vcount          = vcnt;
    assign bus.hsync           = ~hs2;
    assign bus.vsync           = ~vs2;
    assign bus.red             = pix_q[7:5];
    assign bus.green           = pix_q[4:2];
    assign bus.blue            = pix_q[1:0];
    assign bus.frame_start     = fs_q;
    assign bus.collision_valid = fs_q;
    assign bus.collision       = coll;
endmodule

// File: tb/tb_vga_compositor.sv
// Bench for vga_compositor on a shrunken raster (32x15 ticks per frame).
// A tick-index model predicts every output; directed pixels exercise mixing and collisions.
module tb_vga_compositor;
    localparam int L     = 4;
    localparam int HV    = 16;
    localparam int HF    = 4;
    localparam int HS    = 6;
    localparam int HB    = 6;
    localparam int VV    = 8;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [31:0] LRGB = 32'hE3031CFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vga_compositor_if #(.NUM_LAYERS(L)) bus ();

    vga_compositor #(
        .NUM_LAYERS(L),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] top_colour(input logic [L-1:0] ld,
                                              input logic [31:0] rgb,
                                              input logic [7:0] bg);
        for (int k = 0; k < L; k++) begin
            if (ld[k]) return rgb[8*k +: 8];
        end
        return bg;
    endfunction

    // Model: pins after tick n show the pixel counted at tick n-2, mixed with tick-n layer data.
    int           m_n   = 0;
    logic [L-2:0] m_acc = '0;
    logic [L-2:0] m_coll = '0;
    logic         m_pulse = 1'b0;
    logic         m_hs  = 1'b1;
    logic         m_vs  = 1'b1;
    logic [7:0]   m_rgb = '0;
    int           mp, mph, mpv;
    logic         mact;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_n = 0; m_acc = '0; m_coll = '0; m_pulse = 1'b0;
            m_hs = 1'b1; m_vs = 1'b1; m_rgb = '0;
        end else begin
            m_pulse = 1'b0;
            if (bus.enable) begin
                m_n++;
                if (m_n % FRAME == 0) begin
                    m_coll = m_acc;
                    m_acc = '0;
                    m_pulse = 1'b1;
                end
                if (m_n >= 2) begin
                    mp  = m_n - 2;
                    mph = mp % HT;
                    mpv = (mp / HT) % VT;
                    mact = (mph < HV) && (mpv < VV);
                    m_hs = !(mph >= HV + HF && mph < HV + HF + HS);
                    m_vs = !(mpv >= VV + VF && mpv < VV + VF + VS);
                    m_rgb = mact ? top_colour(bus.layer_data, bus.layer_rgb, bus.bg_rgb) : 8'h00;
                    if (mact && bus.layer_data[0]) m_acc = m_acc | bus.layer_data[L-1:1];
                end
            end
        end
    end

    always @(negedge clock) begin
        check("hcount", bus.hcount, m_n % HT);
        check("vcount", bus.vcount, (m_n / HT) % VT);
        check("hsync", bus.hsync, m_hs);
        check("vsync", bus.vsync, m_vs);
        check("rgb", {bus.red, bus.green, bus.blue}, m_rgb);
        check("frame_start", bus.frame_start, m_pulse);
        check("collision_valid", bus.collision_valid, m_pulse);
        check("collision", bus.collision, m_coll);
    end

    int q = 0;

    // Drives the layer inputs for tick q+1, which describe pixel q-1.
    task automatic tick();
        int p, f, r, h, v;
        logic [L-1:0] ld;
        logic [7:0] bg;
        p = q - 1;
        ld = '0;
        f = (p >= 0) ? p / FRAME : 0;
        r = (p >= 0) ? p % FRAME : 0;
        h = r % HT;
        v = r / HT;
        if (p >= 0) begin
            case (f)
                1: begin
                    if (h == 3 && v == 1)       ld = 4'b0110;
                    else if (h == 4 && v == 1)  ld = 4'b0100;
                    else if (h == 5 && v == 2)  ld = 4'b0101;
                    else if (h == 20 && v == 3) ld = 4'b0011;
                end
                2: begin
                    if (h == 20 && v == 3)      ld = 4'b0011;
                    else if (h == 2 && v == 9)  ld = 4'b1111;
                end
                3: if (h == 6 && v == 4) ld = 4'b1001;
                4: if (h == 1 && v == 0) ld = 4'b0011;
                default: ld = '0;
            endcase
        end
        bg = (f == 0) ? 8'hE0 : 8'h25;
        @(negedge clock);
        bus.layer_data = ld;
        bus.layer_rgb  = LRGB;
        bus.bg_rgb     = bg;
        bus.enable     = 1'b1;
        @(negedge clock);
        bus.enable = 1'b0;
        q++;
    endtask

    task automatic run_to(input int n);
        while (q < n) tick();
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.layer_data = '0;
        bus.layer_rgb = LRGB;
        bus.bg_rgb = 8'hE0;
        repeat (3) @(negedge clock);
        check("reset hcount", bus.hcount, 0);
        check("reset hsync", bus.hsync, 1);
        check("reset vsync", bus.vsync, 1);
        check("reset rgb", {bus.red, bus.green, bus.blue}, 8'h00);
        check("reset collision", bus.collision, 0);
        reset = 1'b0;

        run_to(2);   check("first pixel red", {bus.red, bus.green, bus.blue}, 8'hE0);
        run_to(18);  check("hblank rgb", {bus.red, bus.green, bus.blue}, 8'h00);
        run_to(22);  check("hsync low", bus.hsync, 0);
        run_to(28);  check("hsync high", bus.hsync, 1);
        run_to(322); check("vsync low", bus.vsync, 0);
        run_to(386); check("vsync high", bus.vsync, 1);
        run_to(480);
        check("frame0 start", bus.frame_start, 1);
        check("frame0 valid", bus.collision_valid, 1);
        check("frame0 coll", bus.collision, 3'b000);
        check("wrap vcount", bus.vcount, 0);

        run_to(517); check("priority l1", {bus.red, bus.green, bus.blue}, 8'h1C);
        run_to(518); check("priority l2", {bus.red, bus.green, bus.blue}, 8'h03);
        run_to(960);
        check("frame1 coll", bus.collision, 3'b010);
        check("frame1 valid", bus.collision_valid, 1);

        run_to(1000);
        check("pre-freeze hcount", bus.hcount, 8);
        check("pre-freeze rgb", {bus.red, bus.green, bus.blue}, 8'h25);
        repeat (100) @(negedge clock);
        check("frozen hcount", bus.hcount, 8);
        check("frozen vcount", bus.vcount, 1);
        check("frozen rgb", {bus.red, bus.green, bus.blue}, 8'h25);

        run_to(1440); check("frame2 coll", bus.collision, 3'b000);
        run_to(1920); check("frame3 coll", bus.collision, 3'b100);

        run_to(2100);
        #2 reset = 1'b1;
        #1;
        check("async hcount", bus.hcount, 0);
        check("async vcount", bus.vcount, 0);
        check("async hsync", bus.hsync, 1);
        check("async rgb", {bus.red, bus.green, bus.blue}, 8'h00);
        check("async collision", bus.collision, 3'b000);
        @(negedge clock);
        reset = 1'b0;
        q = 0;

        run_to(1);   check("restart hcount", bus.hcount, 1);
        run_to(480);
        check("post-reset coll", bus.collision, 3'b000);
        check("post-reset start", bus.frame_start, 1);
        run_to(490);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
